// File: rtl/fft_meas_sched_if.sv
// Control/status bundle between the FFT measurement sequencer and its surroundings.
// The master drives the keys, shutdown and the ADC/FFT strobes; the sequencer is the slave.
interface fft_meas_sched_if #(
   parameter int AW = 10
);
   logic          key_start;
   logic          key_mode;
   logic          shutdown;
   logic          adc_valid;
   logic          fft_done;
   logic          cap_en;
   logic [AW-1:0] cap_addr;
   logic          fft_start;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          busy;
   logic          done;
   logic          cont_mode;

   modport master (
      output key_start, key_mode, shutdown, adc_valid, fft_done,
      input  cap_en, cap_addr, fft_start, rd_en, rd_addr, busy, done, cont_mode
   );

   modport slave (
      input  key_start, key_mode, shutdown, adc_valid, fft_done,
      output cap_en, cap_addr, fft_start, rd_en, rd_addr, busy, done, cont_mode
   );
endinterface

// File: rtl/fft_meas_sched.sv
// Measurement sequencer: debounced start/mode keys drive one capture -> FFT -> read-out
// frame per press, or back-to-back frames in continuous mode.
module fft_meas_sched #(
   parameter int DEB_CYC = 1_000_000,
   parameter int N_PTS   = 1024,
   parameter int AW      = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fft_meas_sched_if.slave      bus
);
   localparam int            CW       = $clog2(DEB_CYC + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
   localparam logic [AW-1:0] CAP_LAST = AW'(N_PTS - 1);
   localparam logic [AW-1:0] RD_LAST  = AW'(N_PTS / 2 - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CAPTURE  = 3'd1,
      ST_FFT_KICK = 3'd2,
      ST_FFT_WAIT = 3'd3,
      ST_READ     = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   logic [1:0]    key_raw_s;
   logic [1:0]    press_s;
   logic          start_ev_s;
   logic          mode_ev_s;
   logic          cont_r;
   state_t        state_r;
   state_t        state_nxt_s;
   logic          cap_en_r, fft_start_r, rd_en_r, busy_r, done_r;
   logic          cap_en_nxt_s, fft_start_nxt_s, rd_en_nxt_s, busy_nxt_s, done_nxt_s;
   logic [AW-1:0] cap_addr_r, rd_addr_r;
   logic [AW-1:0] cap_addr_nxt_s, rd_addr_nxt_s;

   assign key_raw_s  = {bus.key_mode, bus.key_start};
   assign start_ev_s = press_s[0];
   assign mode_ev_s  = press_s[1];

   for (genvar k = 0; k < 2; k++) begin : g_deb
      logic          sync1_r, sync2_r, deb_r, press_r;
      logic [CW-1:0] cnt_r;

      // Synchronise the raw key, accept a new level after DEB_CYC stable samples, flag 1->0 as a press
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            deb_r   <= 1'b1;
            press_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
         end else begin
            sync1_r <= key_raw_s[k];
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == deb_r) begin
               cnt_r <= {CW{1'b0}};
            end else if (cnt_r == DEB_LAST) begin
               cnt_r   <= {CW{1'b0}};
               deb_r   <= sync2_r;
               press_r <= deb_r;
            end else begin
               cnt_r <= cnt_r + CW'(1);
            end
         end
      end

      assign press_s[k] = press_r;
   end

   // Mode key toggles continuous mode regardless of state or shutdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cont_r <= 1'b0;
      end else if (mode_ev_s) begin
         cont_r <= ~cont_r;
      end else begin
         cont_r <= cont_r;
      end
   end

   // State register together with the registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cap_en_r    <= 1'b0;
         fft_start_r <= 1'b0;
         rd_en_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cap_addr_r  <= {AW{1'b0}};
         rd_addr_r   <= {AW{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         cap_en_r    <= cap_en_nxt_s;
         fft_start_r <= fft_start_nxt_s;
         rd_en_r     <= rd_en_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
         cap_addr_r  <= cap_addr_nxt_s;
         rd_addr_r   <= rd_addr_nxt_s;
      end
   end

   // Next-state logic; shutdown overrides everything, stray events are simply not looked at
   always_comb begin
      state_nxt_s = state_r;
      if (bus.shutdown) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_ev_s) state_nxt_s = ST_CAPTURE;
               else            state_nxt_s = ST_IDLE;
            end
            ST_CAPTURE: begin
               if (bus.adc_valid && (cap_addr_r == CAP_LAST)) state_nxt_s = ST_FFT_KICK;
               else                                           state_nxt_s = ST_CAPTURE;
            end
            ST_FFT_KICK: state_nxt_s = ST_FFT_WAIT;
            ST_FFT_WAIT: begin
               if (bus.fft_done) state_nxt_s = ST_READ;
               else              state_nxt_s = ST_FFT_WAIT;
            end
            ST_READ: begin
               if (rd_addr_r == RD_LAST) state_nxt_s = ST_DONE;
               else                      state_nxt_s = ST_READ;
            end
            ST_DONE: begin
               if (cont_r) state_nxt_s = ST_CAPTURE;
               else        state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Output values for the next cycle; addresses restart at 0 whenever their state is (re)entered
   always_comb begin
      cap_en_nxt_s    = (state_nxt_s == ST_CAPTURE);
      fft_start_nxt_s = (state_nxt_s == ST_FFT_KICK);
      rd_en_nxt_s     = (state_nxt_s == ST_READ);
      done_nxt_s      = (state_nxt_s == ST_DONE);
      busy_nxt_s      = (state_nxt_s != ST_IDLE);
      if ((state_r == ST_CAPTURE) && (state_nxt_s == ST_CAPTURE)) begin
         if (bus.adc_valid) cap_addr_nxt_s = cap_addr_r + AW'(1);
         else               cap_addr_nxt_s = cap_addr_r;
      end else begin
         cap_addr_nxt_s = {AW{1'b0}};
      end
      if ((state_r == ST_READ) && (state_nxt_s == ST_READ)) begin
         rd_addr_nxt_s = rd_addr_r + AW'(1);
      end else begin
         rd_addr_nxt_s = {AW{1'b0}};
      end
   end

   assign bus.cap_en    = cap_en_r;
   assign bus.cap_addr  = cap_addr_r;
   assign bus.fft_start = fft_start_r;
   assign bus.rd_en     = rd_en_r;
   assign bus.rd_addr   = rd_addr_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.cont_mode = cont_r;
endmodule

// File: tb/tb_fft_meas_sched.sv
// Scoreboard bench for fft_meas_sched: stimulus queues expected output events,
// a negedge monitor pops and compares each event the DUT produces.
module tb_fft_meas_sched;
   localparam int DEB = 4;
   localparam int NP  = 8;
   localparam int AW  = 3;

   localparam int K_CAP   = 1;
   localparam int K_FFTS  = 2;
   localparam int K_RD    = 3;
   localparam int K_DONE  = 4;
   localparam int K_BRISE = 5;
   localparam int K_BFALL = 6;
   localparam int K_MODE  = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   exp_q[$];

   fft_meas_sched_if #(.AW(AW)) bus ();

   fft_meas_sched #(.DEB_CYC(DEB), .N_PTS(NP), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic string ev_str(input int e);
      string n;
      case (e / 256)
         K_CAP:   n = "CAP";
         K_FFTS:  n = "FFT_START";
         K_RD:    n = "RD";
         K_DONE:  n = "DONE";
         K_BRISE: n = "BUSY_RISE";
         K_BFALL: n = "BUSY_FALL";
         K_MODE:  n = "MODE";
         default: n = "NONE";
      endcase
      return $sformatf("%s(%0d)", n, e % 256);
   endfunction

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic observe(input int got);
      int e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL event: got %s expected nothing", ev_str(got));
      end else begin
         e = exp_q.pop_front();
         if (e != got) begin
            failures++;
            $display("FAIL event: got %s expected %s", ev_str(got), ev_str(e));
         end
      end
   endtask

   task automatic push(input int kind, input int val);
      exp_q.push_back(kind * 256 + val);
   endtask

   task automatic push_caps(input int n);
      for (int i = 0; i < n; i++) push(K_CAP, i);
   endtask

   task automatic push_frame();
      push_caps(NP);
      push(K_FFTS, 0);
      for (int i = 0; i < NP / 2; i++) push(K_RD, i);
      push(K_DONE, 0);
   endtask

   function automatic int outs();
      return int'({bus.busy, bus.cap_en, bus.rd_en, bus.fft_start, bus.done,
                   bus.cont_mode, bus.cap_addr, bus.rd_addr});
   endfunction

   // Monitor: turn DUT output activity into events and check timing relations
   initial begin
      int   cyc      = 0;
      int   last_cap = -100;
      int   last_rd  = -100;
      int   done_cyc = -100;
      logic pb = 1'b0;
      logic pm = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc == done_cyc + 1) check("after_done_cap_en_eq_busy", int'(bus.cap_en), int'(bus.busy));
         if (bus.cont_mode !== pm) begin
            observe(K_MODE * 256 + int'(bus.cont_mode));
            pm = bus.cont_mode;
         end
         if (bus.busy && !pb) observe(K_BRISE * 256);
         if (bus.cap_en && bus.adc_valid) begin
            observe(K_CAP * 256 + int'(bus.cap_addr));
            last_cap = cyc;
         end
         if (bus.fft_start) begin
            observe(K_FFTS * 256);
            check("fft_start_latency", cyc - last_cap, 1);
         end
         if (bus.rd_en) begin
            observe(K_RD * 256 + int'(bus.rd_addr));
            if (bus.rd_addr != 3'd0) check("rd_consecutive", cyc - last_rd, 1);
            last_rd = cyc;
         end
         if (bus.done) begin
            observe(K_DONE * 256);
            check("done_latency", cyc - last_rd, 1);
            done_cyc = cyc;
         end
         if (!bus.busy && pb) observe(K_BFALL * 256);
         pb = bus.busy;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input bit s, input bit m);
      if (s) bus.key_start = 1'b0;
      if (m) bus.key_mode = 1'b0;
      repeat (10) step();
      bus.key_start = 1'b1;
      bus.key_mode  = 1'b1;
      repeat (10) step();
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         step();
         bus.adc_valid = 1'b1;
         step();
         bus.adc_valid = 1'b0;
      end
   endtask

   // fft_done 20 cycles after capture; optionally press start so its event lands in READ
   task automatic finish_fft(input bit key_in_read);
      repeat (17) step();
      if (key_in_read) bus.key_start = 1'b0;
      repeat (3) step();
      bus.fft_done = 1'b1;
      step();
      bus.fft_done = 1'b0;
      repeat (8) step();
      if (key_in_read) begin
         bus.key_start = 1'b1;
         repeat (10) step();
      end
   endtask

   initial begin
      bus.key_start = 1'b1;
      bus.key_mode  = 1'b1;
      bus.shutdown  = 1'b0;
      bus.adc_valid = 1'b0;
      bus.fft_done  = 1'b0;
      repeat (3) step();
      check("reset_outputs", outs(), 0);
      rst_n = 1'b1;
      repeat (2) step();
      check("idle_after_reset", outs(), 0);

      // bounce then single-shot frame
      push(K_BRISE, 0);
      push_frame();
      push(K_BFALL, 0);
      for (int i = 0; i < 10; i++) begin
         bus.key_start = ~bus.key_start;
         repeat (2) step();
      end
      bus.key_start = 1'b0;
      repeat (10) step();
      bus.key_start = 1'b1;
      repeat (10) step();
      feed(NP);
      finish_fft(1'b0);
      repeat (5) step();

      // continuous: three frames, mode cleared during the third
      push(K_MODE, 1);
      press(1'b0, 1'b1);
      push(K_BRISE, 0);
      push_frame();
      push_frame();
      push(K_MODE, 0);
      push_frame();
      push(K_BFALL, 0);
      press(1'b1, 1'b0);
      feed(NP);
      finish_fft(1'b0);
      feed(NP);
      finish_fft(1'b0);
      press(1'b0, 1'b1);
      feed(NP);
      finish_fft(1'b0);
      repeat (5) step();

      // abort in FFT_WAIT; late fft_done and press under shutdown ignored
      push(K_BRISE, 0);
      push_caps(NP);
      push(K_FFTS, 0);
      push(K_BFALL, 0);
      press(1'b1, 1'b0);
      feed(NP);
      repeat (5) step();
      bus.shutdown = 1'b1;
      step();
      bus.shutdown = 1'b0;
      check("abort_outputs", outs(), 0);
      step();
      bus.fft_done = 1'b1;
      step();
      bus.fft_done = 1'b0;
      repeat (5) step();
      push(K_MODE, 1);
      bus.shutdown = 1'b1;
      press(1'b1, 1'b1);
      bus.shutdown = 1'b0;
      repeat (5) step();
      check("shutdown_press_busy", int'(bus.busy), 0);
      push(K_MODE, 0);
      press(1'b0, 1'b1);

      // stray inputs in IDLE, start press during READ
      bus.fft_done = 1'b1;
      step();
      bus.fft_done  = 1'b0;
      bus.adc_valid = 1'b1;
      step();
      bus.adc_valid = 1'b0;
      step();
      check("stray_idle_busy", int'(bus.busy), 0);
      push(K_BRISE, 0);
      push_frame();
      push(K_BFALL, 0);
      press(1'b1, 1'b0);
      feed(NP);
      finish_fft(1'b1);
      repeat (10) step();
      check("no_extra_frame_busy", int'(bus.busy), 0);

      // async reset mid-capture with continuous mode on
      push(K_MODE, 1);
      press(1'b0, 1'b1);
      push(K_BRISE, 0);
      push_caps(5);
      press(1'b1, 1'b0);
      feed(5);
      check("cap_addr_before_reset", int'(bus.cap_addr), 5);
      push(K_MODE, 0);
      push(K_BFALL, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", outs(), 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (5) step();
      check("held_idle_after_reset", outs(), 0);
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
